pwm_fader: RTL and testbench

- Multi-channel brightness ramp controller that drives the 8-bit `pulse_width` inputs of NUM_CH pwm instances.
- Accepts fade commands (channel, target width, step rate) over a valid/ready interface.
- Walks each channel's width toward its target in ±1 steps, one step every (rate+1) clocks.
- Sits between the register/host logic and the pwm array. It replaces direct width writes so brightness changes are smooth.

---
 rtl/pwm_fader_pkg.sv | 13 +
 rtl/pwm_fader_if.sv | 17 +
 rtl/pwm_fade_ch.sv | 79 +++++++
 rtl/pwm_fader.sv | 55 +++++
 tb/tb_pwm_fader.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/pwm_fader_pkg.sv
// Shared types and constants for the pwm_fader brightness ramp controller.
package pwm_pkg;
   localparam int PW_W = 8;
   localparam logic [PW_W-1:0] PW_MAX = 8'hFF;

   typedef enum logic {FADE_IDLE, FADE_RAMP} fade_state_t;

   // Direction is always toward the target, so the result can never wrap.
   function automatic logic [PW_W-1:0] step_toward(input logic [PW_W-1:0] width,
                                                   input logic [PW_W-1:0] target);
      return (target > width) ? width + 1'b1 : width - 1'b1;
   endfunction
endpackage

// File: rtl/pwm_fader_if.sv
// Fade command channel: host (master) issues channel/target/rate, fader (slave) accepts.
interface pwm_fader_if #(
   parameter int NUM_CH = 4,
   parameter int RATE_W = 16
);
   import pwm_pkg::*;
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [CH_W-1:0]   cmd_ch;
   logic [PW_W-1:0]   cmd_target;
   logic [RATE_W-1:0] cmd_rate;

   modport master (output cmd_valid, cmd_ch, cmd_target, cmd_rate, input cmd_ready);
   modport slave  (input cmd_valid, cmd_ch, cmd_target, cmd_rate, output cmd_ready);
endinterface

// File: rtl/pwm_fade_ch.sv
// One fade channel: IDLE/RAMP FSM, step prescaler and registered width.
// PWM_FADER_RETARGET_EN lets a load during RAMP replace target and rate in flight.
module pwm_fade_ch
   import pwm_pkg::*;
#(
   parameter int RATE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [PW_W-1:0]   i_target,
   input  logic [RATE_W-1:0] i_rate,
   output logic [PW_W-1:0]   o_width,
   output logic              o_busy
);
   fade_state_t       r_state;
   logic [PW_W-1:0]   r_width;
   logic [PW_W-1:0]   r_target;
   logic [RATE_W-1:0] r_rate;
   logic [RATE_W-1:0] r_count;
   logic              r_busy;
   logic [PW_W-1:0]   w_next_width;

   assign w_next_width = step_toward(r_width, r_target);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= FADE_IDLE;
         r_width  <= '0;
         r_target <= '0;
         r_rate   <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            FADE_IDLE: begin
               if (i_load && (i_target != r_width)) begin
                  r_target <= i_target;
                  r_rate   <= i_rate;
                  r_count  <= '0;
                  r_state  <= FADE_RAMP;
                  r_busy   <= 1'b1;
               end
            end
            FADE_RAMP: begin
`ifdef PWM_FADER_RETARGET_EN
               if (i_load) begin
                  // Width and count are kept; only an overrun count is pulled back.
                  r_target <= i_target;
                  r_rate   <= i_rate;
                  if (r_count > i_rate) r_count <= '0;
                  if (i_target == r_width) begin
                     r_state <= FADE_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else
`endif
               if (r_count == r_rate) begin
                  r_count <= '0;
                  r_width <= w_next_width;
                  if (w_next_width == r_target) begin
                     r_state <= FADE_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: begin
               r_state <= FADE_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_width = r_width;
   assign o_busy  = r_busy;
endmodule

// File: rtl/pwm_fader.sv
// Multi-channel brightness fader: decodes fade commands and drives NUM_CH pwm widths.
// Optional in-flight retargeting is enabled with PWM_FADER_RETARGET_EN.
module pwm_fader
   import pwm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int RATE_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   pwm_fader_if.slave             cmd,
   output logic [NUM_CH*PW_W-1:0] pulse_width,
   output logic [NUM_CH-1:0]      busy
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              w_in_range;
   logic              w_sel_busy;
   logic              w_accept;
   logic [NUM_CH-1:0] w_load;

   assign w_in_range = ({1'b0, cmd.cmd_ch} < (CH_W+1)'(NUM_CH));

   always_comb begin
      w_sel_busy = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cmd.cmd_ch == CH_W'(i)) w_sel_busy = busy[i];
      end
   end

`ifdef PWM_FADER_RETARGET_EN
   assign cmd.cmd_ready = !rst;
`else
   // Out-of-range commands are always taken so they cannot stall the host.
   assign cmd.cmd_ready = !rst && (!w_in_range || !w_sel_busy);
`endif

   assign w_accept = cmd.cmd_valid && cmd.cmd_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_load[g] = w_accept && w_in_range && (cmd.cmd_ch == CH_W'(g));

      pwm_fade_ch #(
         .RATE_W (RATE_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_load   (w_load[g]),
         .i_target (cmd.cmd_target),
         .i_rate   (cmd.cmd_rate),
         .o_width  (pulse_width[g*PW_W +: PW_W]),
         .o_busy   (busy[g])
      );
   end
endmodule

// File: tb/tb_pwm_fader.sv
// Directed bench for pwm_fader: reset, up/down ramps, full range, back-pressure, no-op, retarget.
module tb_pwm_fader;
   localparam int NUM_CH = 4;
   localparam int RATE_W = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NUM_CH*8-1:0]  pulse_width;
   logic [NUM_CH-1:0]    busy;
   int                   n_chk  = 0;
   int                   n_pass = 0;

   pwm_fader_if #(.NUM_CH(NUM_CH), .RATE_W(RATE_W)) cmd_if ();

   pwm_fader #(.NUM_CH(NUM_CH), .RATE_W(RATE_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd         (cmd_if.slave),
      .pulse_width (pulse_width),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] wid(input int ch);
      return pulse_width[ch*8 +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input logic [7:0] tgt, input int rate);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_ch     = 2'(ch);
      cmd_if.cmd_target = tgt;
      cmd_if.cmd_rate   = RATE_W'(rate);
   endtask

   // Presents a command for exactly one edge; caller ensures the channel is ready.
   task automatic send(input int ch, input logic [7:0] tgt, input int rate);
      drive(ch, tgt, rate);
      tick();
      cmd_if.cmd_valid = 1'b0;
   endtask

   initial begin
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_ch     = '0;
      cmd_if.cmd_target = '0;
      cmd_if.cmd_rate   = '0;

      // Power-on reset
      tick(); tick();
      check("rst_ready", 32'(cmd_if.cmd_ready), 0);
      check("rst_pw", pulse_width, 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      tick();
      check("rel_ready", 32'(cmd_if.cmd_ready), 1);

      // Up-ramp ch0 to 5 at rate 0
      send(0, 8'h05, 0);
      check("up_busy0", 32'(busy[0]), 1);
      check("up_w0", 32'(wid(0)), 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check($sformatf("up_w%0d", k), 32'(wid(0)), 32'(k));
         check($sformatf("up_busy%0d", k), 32'(busy[0]), (k < 5) ? 1 : 0);
      end

      // Down-ramp ch1 from 3 to 0 at rate 2
      send(1, 8'h03, 0);
      tick(); tick(); tick();
      check("dn_preset", 32'(wid(1)), 3);
      check("dn_preset_busy", 32'(busy[1]), 0);
      send(1, 8'h00, 2);
      for (int k = 1; k <= 9; k++) begin
         tick();
         check($sformatf("dn_w%0d", k), 32'(wid(1)), 32'(3 - k / 3));
         check($sformatf("dn_busy%0d", k), 32'(busy[1]), (k < 9) ? 1 : 0);
      end
      tick(); tick();
      check("dn_floor", 32'(wid(1)), 0);

      // Full-range ramp ch2 with back-pressure and concurrent ch3 command
      send(2, 8'hFF, 0);
      tick();
      check("fr_w1", 32'(wid(2)), 1);
      drive(2, 8'h10, 0);
      #1;
`ifdef PWM_FADER_RETARGET_EN
      check("bp_ready_ch2", 32'(cmd_if.cmd_ready), 1);
`else
      check("bp_ready_ch2", 32'(cmd_if.cmd_ready), 0);
`endif
      drive(3, 8'h02, 0);
      #1;
      check("bp_ready_ch3", 32'(cmd_if.cmd_ready), 1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      check("fr_w2", 32'(wid(2)), 2);
      check("ch3_busy", 32'(busy[3]), 1);
      repeat (252) tick();
      check("fr_wFE", 32'(wid(2)), 8'hFE);
      check("fr_busyFE", 32'(busy[2]), 1);
      tick();
      check("fr_wFF", 32'(wid(2)), 8'hFF);
      check("fr_busyFF", 32'(busy[2]), 0);
      check("ch3_done", 32'(wid(3)), 2);
      tick(); tick(); tick();
      check("fr_nowrap", 32'(wid(2)), 8'hFF);

      // No-op: target equals current width
      send(0, 8'h05, 0);
      check("noop_busy0", 32'(busy[0]), 0);
      tick(); tick();
      check("noop_busy2", 32'(busy[0]), 0);
      check("noop_w", 32'(wid(0)), 5);

      // Reset asserted mid-ramp, between edges
      send(1, 8'h80, 0);
      tick(); tick(); tick();
      check("mid_w", 32'(wid(1)), 3);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_pw", pulse_width, 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_ready", 32'(cmd_if.cmd_ready), 0);
      tick();
      rst = 1'b0;
      tick();
      check("post_ready", 32'(cmd_if.cmd_ready), 1);
      tick(); tick();
      check("post_pw", pulse_width, 0);
      check("post_busy", 32'(busy), 0);

`ifdef PWM_FADER_RETARGET_EN
      // Retarget ch0 mid-ramp and reverse direction
      send(0, 8'h40, 0);
      repeat (32) tick();
      check("rt_w20", 32'(wid(0)), 8'h20);
      drive(0, 8'h10, 0);
      #1;
      check("rt_ready", 32'(cmd_if.cmd_ready), 1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      check("rt_hold", 32'(wid(0)), 8'h20);
      for (int k = 1; k <= 16; k++) begin
         tick();
         check($sformatf("rt_ready%0d", k), 32'(cmd_if.cmd_ready), 1);
      end
      check("rt_w10", 32'(wid(0)), 8'h10);
      check("rt_busy", 32'(busy[0]), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
